// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - two-requester round-robin arbiter in front of a shared SPI byte transmitter
//
// Ports:
//   clk       in   system clock, all state on the rising edge
//   reset_n   in   asynchronous active-low reset
//   req[1:0]  in   per-requester transfer request, held until its done pulse
//   data0     in   byte offered by requester 0
//   data1     in   byte offered by requester 1
//   gnt[1:0]  out  one-hot grant, high from grant until the transfer ends
//   done[1:0] out  one-cycle completion pulse to the granted requester
//   tx_start  out  one-cycle start strobe to the transmitter
//   tx_data   out  byte latched at grant, held for the whole transfer
//   tx_busy   in   transmitter busy, blocks a new grant while high
//   tx_done   in   one-cycle end-of-byte pulse from the transmitter
//   err       out  sticky timeout flag, cleared only by reset

module spi_arbiter #(
    parameter int GAP_CYC = 2,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t        state_q;
    logic [1:0]    gnt_q;
    logic [1:0]    done_q;
    logic          tx_start_q;
    logic [7:0]    tx_data_q;
    logic          err_q;
    logic          ptr_q;      // preferred requester when both request
    logic          src_q;      // requester owning the current transfer
    logic [TW-1:0] to_cnt_q;   // WAIT cycles elapsed without tx_done
    logic [GW-1:0] gap_cnt_q;  // GAP cycles still to spend

    // Winner if a grant happens this cycle: a lone requester always wins,
    // a tie goes to the round-robin pointer.
    logic pick_d;

    always_comb begin
        pick_d = 1'b0;
        if (req == 2'b11) begin
            pick_d = ptr_q;
        end else begin
            pick_d = req[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            err_q      <= 1'b0;
            ptr_q      <= 1'b0;
            src_q      <= 1'b0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
        end else begin
            // Strobes default low so each is high for exactly one cycle.
            tx_start_q <= 1'b0;
            done_q     <= 2'b00;

            case (state_q)
                S_IDLE: begin
                    if ((req != 2'b00) && !tx_busy) begin
                        src_q     <= pick_d;
                        gnt_q     <= pick_d ? 2'b10 : 2'b01;
                        tx_data_q <= pick_d ? data1 : data0;
                        state_q   <= S_START;
                    end
                end

                S_START: begin
                    tx_start_q <= 1'b1;
                    to_cnt_q   <= '0;
                    state_q    <= S_WAIT;
                end

                S_WAIT: begin
                    // A tx_done coinciding with the last timeout cycle counts
                    // as a completion, so it is tested first.
                    if (tx_done || (to_cnt_q == TO_LAST)) begin
                        if (tx_done) begin
                            done_q <= src_q ? 2'b10 : 2'b01;
                        end else begin
                            err_q <= 1'b1;
                        end
                        gnt_q <= 2'b00;
                        ptr_q <= ~src_q;
                        if (GAP_CYC == 0) begin
                            state_q <= S_IDLE;
                        end else begin
                            gap_cnt_q <= GAP_LOAD;
                            state_q   <= S_GAP;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end

                S_GAP: begin
                    if ((gap_cnt_q == GW'(1)) || (gap_cnt_q == '0)) begin
                        gap_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - self-checking scoreboard bench for spi_arbiter

module tb_spi_arbiter;

    localparam int GAP_CYC = 2;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done = 1'b0;
    logic       err;

    always #5 clk = ~clk;

    spi_arbiter #(
        .GAP_CYC(GAP_CYC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .data0   (data0),
        .data1   (data1),
        .gnt     (gnt),
        .done    (done),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .err     (err)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected grant and byte for each transfer, in start order.
    typedef struct packed {
        logic [1:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [1:0] cur_owner = 2'b00;

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("start_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("start_gnt", 32'(gnt), 32'(mon_e.g));
                check_eq("start_data", 32'(tx_data), 32'(mon_e.d));
                cur_owner = mon_e.g;
            end
        end
        if (done !== 2'b00) begin
            check_eq("done_owner", 32'(done), 32'(cur_owner));
        end
    end

    // Transmitter model: tx_done xdly negedges after tx_start; xdly=0 never answers.
    int xdly   = 4;
    int tx_cnt = 0;

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
        end
        if ((tx_start === 1'b1) && (xdly != 0)) tx_cnt = xdly;
    end

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((done === 2'b00) && (n < 300));
        check_eq("done_seen", 32'(done != 2'b00), 32'd1);
    endtask

    task automatic wait_start();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((tx_start !== 1'b1) && (n < 300));
        check_eq("start_seen", 32'(tx_start), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int gap;
        reset_n = 1'b0;
        req     = 2'b00;
        data0   = 8'h00;
        data1   = 8'h00;
        tx_busy = 1'b0;

        // Reset state
        #1;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Single transfer: latency, one-cycle strobes, done clears gnt
        @(negedge clk);
        req   = 2'b01;
        data0 = 8'hA5;
        exp_q.push_back('{g: 2'b01, d: 8'hA5});
        @(negedge clk);
        check_eq("lat_gnt", 32'(gnt), 32'h1);
        check_eq("lat_no_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        check_eq("lat_start", 32'(tx_start), 32'd1);
        @(negedge clk);
        check_eq("start_one_cycle", 32'(tx_start), 32'd0);
        wait_done();
        check_eq("gnt_at_done", 32'(gnt), 32'd0);
        check_eq("data_at_done", 32'(tx_data), 32'hA5);
        req = 2'b00;
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 32'd0);

        // Both requesting: round-robin order and gap length
        pulse_reset();
        @(negedge clk);
        req   = 2'b11;
        data0 = 8'h11;
        data1 = 8'h22;
        exp_q.push_back('{g: 2'b01, d: 8'h11});
        exp_q.push_back('{g: 2'b10, d: 8'h22});
        exp_q.push_back('{g: 2'b01, d: 8'h11});
        for (int k = 0; k < 3; k++) begin
            wait_done();
            check_eq("rr_gnt_at_done", 32'(gnt), 32'd0);
            if (k < 2) begin
                // Idle cycles after the done cycle until the next grant.
                gap = 0;
                @(negedge clk);
                while ((gnt === 2'b00) && (gap < 50)) begin
                    gap++;
                    @(negedge clk);
                end
                check_eq("rr_gap_cycles", 32'(gap), 32'(GAP_CYC));
            end
        end
        req = 2'b00;
        repeat (6) @(negedge clk);
        check_eq("rr_idle_gnt", 32'(gnt), 32'd0);

        // Transmitter busy blocks the grant
        @(negedge clk);
        tx_busy = 1'b1;
        req     = 2'b10;
        data1   = 8'h5A;
        exp_q.push_back('{g: 2'b10, d: 8'h5A});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("busy_no_gnt", 32'(gnt), 32'd0);
            check_eq("busy_no_start", 32'(tx_start), 32'd0);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        check_eq("busy_release_gnt", 32'(gnt), 32'h2);
        wait_done();
        req = 2'b00;
        repeat (4) @(negedge clk);

        // Timeout: tx_done never arrives
        xdly  = 0;
        req   = 2'b01;
        data0 = 8'h77;
        exp_q.push_back('{g: 2'b01, d: 8'h77});
        wait_start();
        repeat (TIMEOUT - 1) @(negedge clk);
        check_eq("to_err_before", 32'(err), 32'd0);
        check_eq("to_gnt_before", 32'(gnt), 32'h1);
        @(negedge clk);
        check_eq("to_err_set", 32'(err), 32'd1);
        check_eq("to_gnt_clear", 32'(gnt), 32'd0);
        check_eq("to_no_done", 32'(done), 32'd0);
        req  = 2'b00;
        xdly = 3;
        repeat (4) @(negedge clk);
        req   = 2'b10;
        data1 = 8'h99;
        exp_q.push_back('{g: 2'b10, d: 8'h99});
        wait_done();
        check_eq("to_err_sticky", 32'(err), 32'd1);
        req = 2'b00;
        repeat (4) @(negedge clk);

        // Data change and req drop after grant do not disturb the transfer
        data0 = 8'h3C;
        req   = 2'b01;
        exp_q.push_back('{g: 2'b01, d: 8'h3C});
        @(negedge clk);
        check_eq("hold_gnt", 32'(gnt), 32'h1);
        data0 = 8'hC3;
        req   = 2'b00;
        wait_done();
        check_eq("hold_data", 32'(tx_data), 32'h3C);
        repeat (4) @(negedge clk);

        // Reset during WAIT: immediate clear, no done, pointer back to 0
        xdly  = 0;
        req   = 2'b10;
        data1 = 8'hEE;
        exp_q.push_back('{g: 2'b10, d: 8'hEE});
        wait_start();
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_gnt", 32'(gnt), 32'd0);
        check_eq("arst_tx_data", 32'(tx_data), 32'd0);
        check_eq("arst_err", 32'(err), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        check_eq("arst_hold_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        xdly    = 3;
        @(negedge clk);
        req   = 2'b11;
        data0 = 8'h4B;
        data1 = 8'hB4;
        exp_q.push_back('{g: 2'b01, d: 8'h4B});
        @(negedge clk);
        check_eq("arst_ptr_gnt", 32'(gnt), 32'h1);
        wait_done();
        req = 2'b00;
        repeat (6) @(negedge clk);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter GAP_CYC, default 2: idle cycles enforced between consecutive transfers (0 allowed).
REQ-002 Parameter TIMEOUT, default 64: max cycles in WAIT for tx_done before abort (>=2).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-requester transfer request; held high until its done pulse.
REQ-006 data0  input  8  byte offered by requester 0.
REQ-007 data1  input  8  byte offered by requester 1.
REQ-008 gnt  output  2  one-hot grant; high from grant until transfer ends.
REQ-009 done  output  2  one-cycle completion pulse to the granted requester.
REQ-010 tx_start  output  1  one-cycle start strobe to shared SPI transmitter.
REQ-011 tx_data  output  8  latched byte for transmitter; stable from START until transfer ends.
REQ-012 tx_busy  input  1  transmitter busy; no new start issued while high.
REQ-013 tx_done  input  1  one-cycle pulse from transmitter at end of byte.
REQ-014 err  output  1  sticky timeout flag.

Function
REQ-015 FSM states IDLE, START, WAIT, GAP; exactly one active.
REQ-016 IDLE: when req!=0 and tx_busy=0, select requester, latch its data into tx_data, set gnt one-hot, record src, go START next cycle.
REQ-017 IDLE with req!=0 and tx_busy=1: remain IDLE, gnt=0, no latch.
REQ-018 Arbitration round-robin: 1-bit pointer names the preferred requester; both requesting -> pointer's requester wins; single requester always wins.
REQ-019 Pointer reset value 0; after each transfer end (done or timeout) pointer = other than src.
REQ-020 START: tx_start=1 for exactly this cycle; WAIT entered next cycle; timeout counter cleared.
REQ-021 WAIT: timeout counter increments each cycle tx_done=0.
REQ-022 WAIT with tx_done=1: done[src]=1 for one cycle, gnt cleared same cycle, go GAP (or IDLE if GAP_CYC=0).
REQ-023 WAIT with counter reaching TIMEOUT-1 and tx_done=0: err set to 1, gnt cleared, done not pulsed, go GAP (or IDLE if GAP_CYC=0).
REQ-024 tx_done in same cycle as timeout: treated as completion; err unchanged.
REQ-025 tx_done outside WAIT ignored.
REQ-026 GAP: down-counter loaded with GAP_CYC on entry; IDLE entered after GAP_CYC cycles; gnt=0 throughout.
REQ-027 req deasserted by granted requester mid-transfer: ignored; transfer completes, done still pulsed.
REQ-028 data0/data1 changes after grant do not affect tx_data.
REQ-029 err cleared only by reset.
REQ-030 Latency: req rise (IDLE, tx_busy=0) -> gnt at edge+1, tx_start at edge+2.

Reset
REQ-031 reset_n low asynchronously forces: state IDLE, gnt=0, done=0, tx_start=0, tx_data=0x00, err=0, pointer=0, counters=0.
REQ-032 Reset mid-transfer aborts with no done pulse; first edge after release evaluates IDLE normally.

Verification
REQ-033 req=01, data0=0xA5, tx_done 4 cycles after tx_start -> gnt=01, tx_start one cycle, tx_data=0xA5, done=01 one cycle, gnt=00.
REQ-034 req=11 held, data0=0x11, data1=0x22, tx_done each transfer -> order 0x11,0x22,0x11; GAP_CYC=2 idle cycles between gnt drop and next gnt.
REQ-035 req=10, tx_busy=1 for 5 cycles -> gnt=00 and no tx_start until tx_busy falls; then gnt=10 next edge.
REQ-036 req=01, tx_done never asserted, TIMEOUT=64 -> err=1 at 64th WAIT cycle, gnt=00, done=00; req=10 next served normally, err stays 1.
REQ-037 reset_n pulsed low during WAIT -> all outputs zero immediately; no done pulse; pointer=0.
REQ-038 data0 changed 0x3C->0xC3 one cycle after gnt=01 -> tx_data remains 0x3C until transfer ends.
